// File: rtl/val2_shift_unit_pkg.sv
// val2_shift_unit_pkg: shift types, FSM states and operand-2 field positions shared by the Val2 shifter.
package val2_shift_unit_pkg;
  typedef enum logic [2:0] {
    SH_LSL = 3'd0,
    SH_LSR = 3'd1,
    SH_ASR = 3'd2,
    SH_ROR = 3'd3,
    SH_RRX = 3'd4
  } shift_t;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  localparam int IMM8_MSB   = 7;
  localparam int ROT_LSB    = 8;
  localparam int ROT_MSB    = 11;
  localparam int SHAMT_LSB  = 7;
  localparam int SHAMT_MSB  = 11;
  localparam int SHTYPE_LSB = 5;
  localparam int SHTYPE_MSB = 6;
  localparam int REGSH_BIT  = 4;
endpackage

// File: rtl/val2_shift_unit_if.sv
// val2_shift_unit_if: request/result handshake bundle; carry_out exists only with VAL2_CARRY_OUT_EN.
interface val2_shift_unit_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic             mem_rw;
  logic             imm;
  logic [11:0]      shift_operand;
  logic [WIDTH-1:0] val_rm;
  logic [7:0]       val_rs;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
`ifdef VAL2_CARRY_OUT_EN
  logic             carry_out;
`endif
  modport master (
    output in_valid, mem_rw, imm, shift_operand, val_rm, val_rs, carry_in, out_ready,
    input  in_ready, out_valid, out
`ifdef VAL2_CARRY_OUT_EN
    , input carry_out
`endif
  );
  modport slave (
    input  in_valid, mem_rw, imm, shift_operand, val_rm, val_rs, carry_in, out_ready,
    output in_ready, out_valid, out
`ifdef VAL2_CARRY_OUT_EN
    , output carry_out
`endif
  );
endinterface

// File: rtl/val2_shift_unit_step_shifter.sv
// val2_step_shifter: one combinational shift step of 0..STEP positions; last-out bit only with VAL2_CARRY_OUT_EN.
module val2_step_shifter
  import val2_shift_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int NW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] v,
  input  logic [NW-1:0]    n,
  input  shift_t           ty,
  input  logic             fill,
  output logic [WIDTH-1:0] res
`ifdef VAL2_CARRY_OUT_EN
  , output logic           last
`endif
);
  // fill feeds the ASR sign and the RRX carry; logical right shifts get zeros
  always_comb
    res = (ty == SH_LSL) ? v << n :
          (ty == SH_ROR) ? (v >> n) | (v << (WIDTH - int'(n))) :
          (ty == SH_RRX) ? {fill, v[WIDTH-1:1]} :
          WIDTH'({{STEP{fill & (ty == SH_ASR)}}, v} >> n);
`ifdef VAL2_CARRY_OUT_EN
  always_comb
    last = (n == '0) ? 1'b0 :
           (ty == SH_LSL) ? |(v & (WIDTH'(1) << (WIDTH - int'(n)))) :
           (ty == SH_LSR || ty == SH_ASR) ? |(v & (WIDTH'(1) << (int'(n) - 1))) :
           (ty == SH_RRX) ? v[0] : res[WIDTH-1];
`endif
endmodule

// File: rtl/val2_shift_unit.sv
// val2_shift_unit: iterative ARM operand-2 generator (IDLE/SHIFT/DONE); VAL2_CARRY_OUT_EN adds carry_out.
module val2_shift_unit
  import val2_shift_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input logic clk,
  input logic rst_n,
  val2_shift_unit_if.slave bus
);
  localparam int AW = $clog2(WIDTH + 2);
  localparam int NW = $clog2(STEP + 1);
  state_t           state;
  shift_t           ty, d_ty;
  logic [WIDTH-1:0] val, d_val, step_res;
  logic [AW-1:0]    rem, d_amt, rmod;
  logic [NW-1:0]    n;
  logic             fill, d_fill, rdy, vld;
  logic [4:0]       sh;
  logic [1:0]       st;
`ifdef VAL2_CARRY_OUT_EN
  logic             carry, last;
`endif
  always_comb begin
    sh     = bus.shift_operand[SHAMT_MSB:SHAMT_LSB];
    st     = bus.shift_operand[SHTYPE_MSB:SHTYPE_LSB];
    rmod   = AW'(int'(bus.val_rs) % WIDTH);
    d_val  = bus.val_rm;
    d_ty   = shift_t'({1'b0, st});
    d_amt  = '0;
    d_fill = (st == 2'b10) ? bus.val_rm[WIDTH-1] : bus.carry_in;
    if (bus.mem_rw)
      d_val = WIDTH'(bus.shift_operand);
    else if (bus.imm) begin
      d_val = WIDTH'(bus.shift_operand[IMM8_MSB:0]);
      d_ty  = SH_ROR;
      d_amt = AW'({bus.shift_operand[ROT_MSB:ROT_LSB], 1'b0});
    end else if (!bus.shift_operand[REGSH_BIT]) begin
      // amount-0 immediate encodings stand for LSR/ASR #WIDTH and RRX
      d_amt = (sh != '0) ? AW'(sh) : (st == 2'b01 || st == 2'b10) ? AW'(WIDTH) : (st == 2'b11) ? AW'(1) : '0;
      d_ty  = (sh == '0 && st == 2'b11) ? SH_RRX : d_ty;
    end else
      d_amt = (st == 2'b11) ? rmod : (int'(bus.val_rs) > WIDTH) ? AW'(WIDTH + 1) : AW'(bus.val_rs);
  end
  assign n = (rem > AW'(STEP)) ? NW'(STEP) : rem[NW-1:0];
  val2_step_shifter #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .v    (val),
    .n    (n),
    .ty   (ty),
    .fill (fill),
    .res  (step_res)
`ifdef VAL2_CARRY_OUT_EN
    , .last (last)
`endif
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      rdy   <= 1'b1;
      vld   <= 1'b0;
      val   <= '0;
      rem   <= '0;
      ty    <= SH_LSL;
      fill  <= 1'b0;
`ifdef VAL2_CARRY_OUT_EN
      carry <= 1'b0;
`endif
    end else
      case (state)
        ST_IDLE:
          if (bus.in_valid) begin
            val   <= d_val;
            ty    <= d_ty;
            rem   <= d_amt;
            fill  <= d_fill;
            rdy   <= 1'b0;
            vld   <= (d_amt == '0);
            state <= (d_amt == '0) ? ST_DONE : ST_SHIFT;
`ifdef VAL2_CARRY_OUT_EN
            // a register ROR by a nonzero multiple of WIDTH leaves rm intact but carries its MSB
            carry <= (!bus.mem_rw && !bus.imm && bus.shift_operand[REGSH_BIT] && st == 2'b11 &&
                      bus.val_rs != '0 && rmod == '0) ? bus.val_rm[WIDTH-1] : bus.carry_in;
`endif
          end
        ST_SHIFT: begin
          val   <= step_res;
          rem   <= rem - AW'(n);
          vld   <= (rem == AW'(n));
          state <= (rem == AW'(n)) ? ST_DONE : ST_SHIFT;
`ifdef VAL2_CARRY_OUT_EN
          carry <= last;
`endif
        end
        default:
          if (bus.out_ready) begin
            state <= ST_IDLE;
            vld   <= 1'b0;
            rdy   <= 1'b1;
          end
      endcase
  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.out       = val;
`ifdef VAL2_CARRY_OUT_EN
  assign bus.carry_out = carry;
`endif
endmodule

// File: tb/tb_val2_shift_unit.sv
// tb_val2_shift_unit: directed and random requests checked against a bit-serial reference model.
module tb_val2_shift_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  val2_shift_unit_if #(.WIDTH(32)) bus ();
  val2_shift_unit #(.WIDTH(32), .STEP(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  // one bit position per loop iteration, straight from the ARM shifter rules
  function automatic void model(input logic m, input logic i, input logic [11:0] so, input logic [31:0] rm,
                                input logic [7:0] rs, input logic cin,
                                output logic [31:0] r, output logic c, output int amt);
    int kind;
    r = rm;
    c = cin;
    amt = 0;
    kind = 0;
    if (m) begin
      r = {20'b0, so};
      return;
    end
    if (i) begin
      r = {24'b0, so[7:0]};
      kind = 3;
      amt = 2 * int'(so[11:8]);
    end else begin
      kind = int'(so[6:5]);
      if (!so[4]) begin
        amt = int'(so[11:7]);
        if (amt == 0 && (kind == 1 || kind == 2)) amt = 32;
        else if (amt == 0 && kind == 3) begin
          kind = 4;
          amt = 1;
        end
      end else begin
        amt = int'(rs);
        if (kind == 3 && amt != 0) begin
          amt = amt % 32;
          if (amt == 0) begin
            c = rm[31];
            return;
          end
        end else if (amt > 32) amt = 33;
      end
    end
    for (int k = 0; k < amt; k++) begin
      case (kind)
        0: begin c = r[31]; r = r << 1; end
        1: begin c = r[0]; r = r >> 1; end
        2: begin c = r[0]; r = {rm[31], r[31:1]}; end
        3: begin c = r[0]; r = {r[0], r[31:1]}; end
        default: begin c = r[0]; r = {cin, r[31:1]}; end
      endcase
    end
  endfunction
  task automatic run(input logic m, input logic i, input logic [11:0] so, input logic [31:0] rm,
                     input logic [7:0] rs, input logic cin, input logic [31:0] eo, input logic ec,
                     input int el, input int hold);
    int lat;
    @(negedge clk);
    bus.mem_rw = m;
    bus.imm = i;
    bus.shift_operand = so;
    bus.val_rm = rm;
    bus.val_rs = rs;
    bus.carry_in = cin;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    lat = 1;
    bus.in_valid = 1'b0;
    bus.mem_rw = 1'($urandom);
    bus.imm = 1'($urandom);
    bus.shift_operand = 12'($urandom);
    bus.val_rm = $urandom;
    bus.val_rs = 8'($urandom);
    bus.carry_in = 1'($urandom);
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(el));
    chk("out", bus.out, eo);
    chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
`ifdef VAL2_CARRY_OUT_EN
    chk("carry_out", 32'(bus.carry_out), 32'(ec));
`else
    if (ec === 1'bx) $display("carry expectation unknown");
`endif
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk("hold_out", bus.out, eo);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("release_valid", 32'(bus.out_valid), 32'd0);
    chk("release_ready", 32'(bus.in_ready), 32'd1);
  endtask
  initial begin
    logic [11:0] so;
    logic [31:0] rm, eo;
    logic [7:0]  rs;
    logic        m, i, cin, ec;
    int          amt;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.mem_rw = 1'b0;
    bus.imm = 1'b0;
    bus.shift_operand = '0;
    bus.val_rm = '0;
    bus.val_rs = '0;
    bus.carry_in = 1'b0;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out", bus.out, 32'd0);
`ifdef VAL2_CARRY_OUT_EN
    chk("rst_carry", 32'(bus.carry_out), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 0, 12'hABC, 32'h12345678, 8'd0, 0, 32'h00000ABC, 0, 1, 0);
    run(0, 1, 12'h4FF, 32'h0, 8'd0, 0, 32'hFF000000, 1, 3, 0);
    run(0, 0, 12'h280, 32'h80000001, 8'd0, 0, 32'h00000020, 0, 3, 0);
    run(0, 0, 12'h040, 32'h80000000, 8'd0, 0, 32'hFFFFFFFF, 1, 9, 0);
    run(0, 0, 12'h070, 32'h0000000F, 8'd36, 0, 32'hF0000000, 1, 2, 0);
    run(0, 0, 12'h070, 32'h0000000F, 8'd0, 1, 32'h0000000F, 1, 1, 5);
    run(0, 0, 12'h010, 32'h00000001, 8'd32, 0, 32'h00000000, 1, 9, 0);
    run(0, 0, 12'h010, 32'hFFFFFFFF, 8'd200, 1, 32'h00000000, 0, 10, 0);
    run(0, 0, 12'h050, 32'h80000000, 8'd40, 0, 32'hFFFFFFFF, 1, 10, 0);
    run(0, 0, 12'h060, 32'h00000003, 8'd0, 1, 32'h80000001, 1, 2, 0);
    run(0, 0, 12'h070, 32'h80000001, 8'd64, 0, 32'h80000001, 1, 1, 0);
    run(0, 0, 12'h030, 32'h80000000, 8'd32, 0, 32'h00000000, 1, 9, 0);
    for (int t = 0; t < 60; t++) begin
      m = ($urandom_range(0, 7) == 0);
      i = ($urandom_range(0, 3) == 0);
      so = 12'($urandom);
      rm = $urandom;
      cin = 1'($urandom);
      case ($urandom_range(0, 3))
        0: rs = 8'd0;
        1: rs = 8'($urandom_range(30, 34));
        default: rs = 8'($urandom);
      endcase
      model(m, i, so, rm, rs, cin, eo, ec, amt);
      run(m, i, so, rm, rs, cin, eo, ec, (amt + 3) / 4 + 1, int'($urandom_range(0, 2)));
    end
    @(negedge clk);
    bus.mem_rw = 1'b0;
    bus.imm = 1'b0;
    bus.shift_operand = 12'h040;
    bus.val_rm = 32'h80000000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_shift_busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_out", bus.out, 32'd0);
    chk("async_rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 0, 12'h280, 32'h80000001, 8'd0, 0, 32'h00000020, 0, 3, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/val2_shift_unit.md
# val2_shift_unit

- Parametrised, multi-cycle successor to the Val2 operand generator in the EXE stage.
- Accepts one operand-2 request per handshake and produces the ARM second operand:
  - memory offset
  - rotated 8-bit immediate
  - immediate-amount shift of Rm
  - register-amount shift of Rm (new)
- Shifting is iterative, up to STEP bit positions per cycle, so width and area trade against latency.
- Sits between the ID/EXE register and the ALU; valid/ready on both sides lets the hazard unit stall the pipeline.

## Interface
- WIDTH, 32: datapath width; must be ≥ 32.
- STEP, 4: maximum bit positions shifted per cycle; power of two, 1..WIDTH.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request (IDLE only).
- mem_rw  in  1  memory instruction; operand is the 12-bit offset.
- imm  in  1  immediate operand.
- shift_operand  in  12  instruction bits [11:0].
- val_rm  in  WIDTH  Rm value.
- val_rs  in  8  Rs[7:0]; shift amount when shift_operand[4]=1.
- carry_in  in  1  current C flag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  operand-2 result.
- carry_out  out  1  shifter carry; present only with VAL2_CARRY_OUT_EN.

## Operation
FSM has three states:
- IDLE: in_ready=1. On in_valid, capture operands, compute the effective op and amount, then go to SHIFT if amount>0, else DONE.
- SHIFT: shift by min(remaining, STEP) each cycle and decrement remaining; go to DONE when remaining reaches 0.
- DONE: out_valid=1 with out/carry_out held stable; on out_ready return to IDLE. There is no accept in the same cycle.

Request decode (priority order):
- mem_rw=1: out = zero-extended shift_operand; amount 0.
- imm=1: zero-extended shift_operand[7:0], ROR by 2*shift_operand[11:8]. Carry = carry_in if rotate is 0, else result MSB.
- imm=0, bit4=0: amount = shift_operand[11:7]; type = [6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR). Amount-0 encodings:
  - LSL#0: out=val_rm, carry=carry_in.
  - LSR#0: treated as LSR#WIDTH.
  - ASR#0: treated as ASR#WIDTH.
  - ROR#0: RRX, i.e. {carry_in, rm[WIDTH-1:1]}, carry=rm[0], 1 SHIFT cycle.
- imm=0, bit4=1: amount = val_rs[7:0].
  - Amount 0: out=val_rm, carry=carry_in.
  - LSL/LSR/ASR with amount>WIDTH: saturate to WIDTH+1, giving 0 (LSL/LSR, carry 0) or all sign bits (ASR, carry=sign). Amount exactly WIDTH keeps carry = last bit out.
  - ROR: amount mod WIDTH. If the result is 0 with a nonzero original amount, out=val_rm, carry=rm[WIDTH-1], no SHIFT cycles.
- carry tracks the last bit shifted out in each SHIFT step. ASR fills with the captured sign bit.
- Input fields are sampled only at accept; later changes are ignored.

## Timing
- Reset values: state IDLE; in_ready=1, out_valid=0, out=0, carry_out=0, internal remaining=0.
- Latency: out_valid rises N+1 cycles after the accept edge, where N=ceil(effective_amount/STEP). N=0 gives 1 cycle.
- Worst case (WIDTH=32, STEP=4, saturated 33) is N=9, i.e. 10 cycles.
- Throughput: one result per N+2 cycles at most; IDLE always costs one cycle.
- Backpressure: out_ready low in DONE holds all outputs indefinitely.
- Reset asserted in any state returns immediately to reset values; the in-flight request is dropped.

## Configuration
- VAL2_CARRY_OUT_EN defined: the carry_out port and the carry tracking register exist, with the behaviour above.
- Not defined: port and register are removed; the shift datapath is unchanged.

## Structure
- The shared package holds:
  - shift-type enum: SH_LSL, SH_LSR, SH_ASR, SH_ROR, SH_RRX
  - FSM state enum
  - the constant operand-2 field positions (IMM8, ROT, SHAMT, SHTYPE, REGSH bit)
- One sub-module, val2_step_shifter: combinational, shifts a WIDTH value by 0..STEP for a given type and returns value plus last-out bit. The top holds the FSM and registers.

## Test plan
All with WIDTH=32, STEP=4.
- mem_rw=1, shift_operand=12'hABC -> out=32'h00000ABC, out_valid 1 cycle after accept.
- imm=1, shift_operand=12'h4FF, carry_in=0 -> out=32'hFF000000, carry_out=1, latency 3.
- LSL#5: shift_operand=12'h280, val_rm=32'h80000001 -> out=32'h00000020, carry_out=0, latency 3.
- ASR#0 (ASR#32): shift_operand=12'h040, val_rm=32'h80000000 -> out=32'hFFFFFFFF, carry_out=1, latency 9.
- Register ROR: shift_operand=12'h070, val_rs=8'd36, val_rm=32'h0000000F -> out=32'hF0000000, carry_out=1, latency 2. Repeat with val_rs=0 -> out=val_rm, carry_out=carry_in, latency 1.
- Hold out_ready=0 for 5 cycles in DONE -> out stable, in_ready=0. Then assert rst_n=0 during a SHIFT -> out_valid=0, out=0, in_ready=1 immediately.
